// File: rtl/eb_rr_arb.sv
// rtl/eb_rr_arb.sv - round-robin arbiter feeding a 2-entry elastic output stage (optional burst lock: EB_ARB_LOCK_EN)
module eb_rr_arb #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rstf,
    input  logic [NREQ*DWIDTH-1:0] t_data,
    input  logic [NREQ-1:0]        t_valid,
    input  logic [NREQ-1:0]        t_last,
    output logic [NREQ-1:0]        t_ready,
    output logic [DWIDTH-1:0]      i_data,
    output logic                   i_last,
    output logic [IDW-1:0]         i_id,
    output logic                   i_valid,
    input  logic                   i_ready
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state_q, state_d;
    logic              space_q, space_d;
    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
    logic              hd_last_q, hd_last_d, tl_last_q, tl_last_d;
    logic [IDW-1:0]    hd_id_q, hd_id_d, tl_id_q, tl_id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
`ifdef EB_ARB_LOCK_EN
    logic              lock_q, lock_d;
    logic [IDW-1:0]    lockid_q, lockid_d;
`endif

    logic [IDW-1:0]    gnt;
    logic              gnt_vld;
    logic [IDW-1:0]    ptr_inc;
    logic              acc;
    logic              pop;
    logic [DWIDTH-1:0] acc_data;
    logic              acc_last;
    int                idx;
    logic [IDW-1:0]    sel;

    // Grant search: walk down from the farthest offset so the requester closest to ptr wins
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IDW'(idx);
            if (t_valid[sel]) begin
                gnt     = sel;
                gnt_vld = 1'b1;
            end
        end
`ifdef EB_ARB_LOCK_EN
        if (lock_q) begin
            gnt     = lockid_q;
            gnt_vld = t_valid[lockid_q];
        end
`endif
    end

    // Accept strobe: space is registered so t_ready never sees i_ready; forced low in reset
    always_comb begin
        acc          = rstf & space_q & gnt_vld;
        t_ready      = '0;
        t_ready[gnt] = acc;
        acc_data     = t_data[int'(gnt)*DWIDTH +: DWIDTH];
        acc_last     = t_last[gnt];
        pop          = valid_q & i_ready;
        ptr_inc      = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
    end

    // Next-state for pointer, lock and the two-entry output queue
    always_comb begin
        state_d   = state_q;
        hd_data_d = hd_data_q;
        hd_last_d = hd_last_q;
        hd_id_d   = hd_id_q;
        tl_data_d = tl_data_q;
        tl_last_d = tl_last_q;
        tl_id_d   = tl_id_q;
        ptr_d     = ptr_q;
`ifdef EB_ARB_LOCK_EN
        lock_d    = lock_q;
        lockid_d  = lockid_q;
        if (acc) begin
            if (acc_last) begin
                lock_d = 1'b0;
                ptr_d  = ptr_inc;
            end else begin
                lock_d   = 1'b1;
                lockid_d = gnt;
            end
        end
`else
        if (acc) begin
            ptr_d = ptr_inc;
        end
`endif
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    hd_data_d = acc_data;
                    hd_last_d = acc_last;
                    hd_id_d   = gnt;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (acc && pop) begin
                    hd_data_d = acc_data;
                    hd_last_d = acc_last;
                    hd_id_d   = gnt;
                end else if (acc) begin
                    tl_data_d = acc_data;
                    tl_last_d = acc_last;
                    tl_id_d   = gnt;
                    state_d   = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    hd_data_d = tl_data_q;
                    hd_last_d = tl_last_q;
                    hd_id_d   = tl_id_q;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        space_d = (state_d != FULL);
        valid_d = (state_d != EMPTY);
    end

    // State registers; reset discards queued beats and clears pointer and lock
    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state_q   <= EMPTY;
            space_q   <= 1'b1;
            valid_q   <= 1'b0;
            hd_data_q <= '0;
            hd_last_q <= 1'b0;
            hd_id_q   <= '0;
            tl_data_q <= '0;
            tl_last_q <= 1'b0;
            tl_id_q   <= '0;
            ptr_q     <= '0;
`ifdef EB_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lockid_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            space_q   <= space_d;
            valid_q   <= valid_d;
            hd_data_q <= hd_data_d;
            hd_last_q <= hd_last_d;
            hd_id_q   <= hd_id_d;
            tl_data_q <= tl_data_d;
            tl_last_q <= tl_last_d;
            tl_id_q   <= tl_id_d;
            ptr_q     <= ptr_d;
`ifdef EB_ARB_LOCK_EN
            lock_q    <= lock_d;
            lockid_q  <= lockid_d;
`endif
        end
    end

    assign i_data  = hd_data_q;
    assign i_last  = hd_last_q;
    assign i_id    = hd_id_q;
    assign i_valid = valid_q;

endmodule

// File: tb/tb_eb_rr_arb.sv
// tb/tb_eb_rr_arb.sv - directed scoreboard bench for eb_rr_arb
module tb_eb_rr_arb;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rstf;
    logic [NREQ*DW-1:0]   t_data;
    logic [NREQ-1:0]      t_valid;
    logic [NREQ-1:0]      t_last;
    logic [NREQ-1:0]      t_ready;
    logic [DW-1:0]        i_data;
    logic                 i_last;
    logic [IDW-1:0]       i_id;
    logic                 i_valid;
    logic                 i_ready;

    always #5 clk = ~clk;

    eb_rr_arb #(.NREQ(NREQ), .DWIDTH(DW), .IDW(IDW)) dut (
        .clk     (clk),
        .rstf    (rstf),
        .t_data  (t_data),
        .t_valid (t_valid),
        .t_last  (t_last),
        .t_ready (t_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_id    (i_id),
        .i_valid (i_valid),
        .i_ready (i_ready)
    );

    typedef struct packed {
        logic [DW-1:0]  d;
        logic           l;
        logic [IDW-1:0] id;
    } beat_t;

    beat_t         sb[$];
    int            acc_ids[$];
    int            pop_ids[$];
    logic [DW-1:0] pop_data[$];
    int            mptr;
    bit            mlock;
    int            mlockid;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pay(input logic [7:0] base);
        for (int k = 0; k < NREQ; k++) begin
            t_data[k*DW +: DW] = {24'h0, base} + DW'(k);
        end
    endtask

    task automatic clr_logs();
        acc_ids.delete();
        pop_ids.delete();
        pop_data.delete();
    endtask

    // One clock: predict, compare at negedge, update the model, return 1ns after posedge
    task automatic cyc();
        int         g;
        bit         found;
        bit         acc;
        logic [3:0] exp_rdy;
        beat_t      e;
        beat_t      nb;
        @(negedge clk);
        for (int k = 0; k < NREQ; k++) begin
            if (t_ready[k]) acc_ids.push_back(k);
        end
        if (i_valid && i_ready) begin
            pop_ids.push_back(int'(i_id));
            pop_data.push_back(i_data);
        end
        if (!rstf) begin
            sb.delete();
            mptr    = 0;
            mlock   = 0;
            mlockid = 0;
            chk("rst_t_ready", 64'(t_ready), 64'd0);
            chk("rst_i_valid", 64'(i_valid), 64'd0);
            chk("rst_i_data",  64'(i_data),  64'd0);
            chk("rst_i_id",    64'(i_id),    64'd0);
        end else begin
            found = 0;
            g     = 0;
            if (mlock) begin
                g     = mlockid;
                found = t_valid[g];
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    int k;
                    k = (mptr + i) % NREQ;
                    if (!found && t_valid[k]) begin
                        found = 1;
                        g     = k;
                    end
                end
            end
            acc     = found && (sb.size() < 2);
            exp_rdy = acc ? 4'(1 << g) : 4'd0;
            chk("t_ready", 64'(t_ready), 64'(exp_rdy));
            chk("i_valid", 64'(i_valid), 64'(sb.size() > 0));
            if (sb.size() > 0 && i_ready) begin
                e = sb.pop_front();
                chk("i_data", 64'(i_data), 64'(e.d));
                chk("i_id",   64'(i_id),   64'(e.id));
                chk("i_last", 64'(i_last), 64'(e.l));
            end
            if (acc) begin
                nb.d  = t_data[g*DW +: DW];
                nb.l  = t_last[g];
                nb.id = IDW'(g);
                sb.push_back(nb);
`ifdef EB_ARB_LOCK_EN
                if (t_last[g]) begin
                    mlock = 0;
                    mptr  = (g + 1) % NREQ;
                end else begin
                    mlock   = 1;
                    mlockid = g;
                end
`else
                mptr = (g + 1) % NREQ;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstf    = 1'b0;
        t_valid = '0;
        t_last  = '1;
        i_ready = 1'b1;
        t_data  = '0;
        set_pay(8'hA0);
        repeat (2) cyc();
        rstf = 1'b1;

        // Idle after reset
        cyc();
        chk("idle_ready", 64'(t_ready), 64'd0);
        chk("idle_id",    64'(i_id),    64'd0);

        // All requesters valid, full-rate rotation
        clr_logs();
        t_valid = 4'b1111;
        cyc();
        chk("lat_valid", 64'(i_valid), 64'd1);
        chk("lat_id",    64'(i_id),    64'd0);
        repeat (7) cyc();
        chk("rot_npop", 64'(pop_ids.size()), 64'd7);
        for (int i = 0; i < pop_ids.size() && i < 7; i++) begin
            chk("rot_id", 64'(pop_ids[i]), 64'(i % 4));
        end

        // Single active requester granted every cycle
        clr_logs();
        t_valid = 4'b0100;
        repeat (6) cyc();
        chk("single_nacc", 64'(acc_ids.size()), 64'd6);
        foreach (acc_ids[i]) chk("single_acc", 64'(acc_ids[i]), 64'd2);
        for (int i = 1; i < pop_ids.size(); i++) begin
            chk("single_pop", 64'(pop_ids[i]), 64'd2);
        end

        // Move ptr back to 0 and drain
        t_valid = 4'b1000;
        cyc();
        t_valid = 4'b0000;
        repeat (2) cyc();

        // Backpressure fills the stage in two accepts
        clr_logs();
        t_valid = 4'b1111;
        i_ready = 1'b0;
        repeat (4) cyc();
        chk("bp_nacc", 64'(acc_ids.size()), 64'd2);
        if (acc_ids.size() == 2) begin
            chk("bp_acc0", 64'(acc_ids[0]), 64'd0);
            chk("bp_acc1", 64'(acc_ids[1]), 64'd1);
        end
        chk("bp_ready", 64'(t_ready), 64'd0);
        clr_logs();
        i_ready = 1'b1;
        repeat (4) cyc();
        chk("bp_npop", 64'(pop_ids.size()), 64'd4);
        if (pop_ids.size() >= 3) begin
            chk("bp_pop0", 64'(pop_data[0]), 64'hA0);
            chk("bp_pop1", 64'(pop_data[1]), 64'hA1);
            chk("bp_pop2", 64'(pop_ids[2]),  64'd2);
        end
        if (acc_ids.size() > 0) chk("bp_resume", 64'(acc_ids[0]), 64'd2);
        else chk("bp_resume_none", 64'd0, 64'd1);
        t_valid = 4'b0000;
        repeat (2) cyc();

`ifdef EB_ARB_LOCK_EN
        // Burst lock on requester 1 with a valid gap mid-burst
        t_last  = 4'b1111;
        t_valid = 4'b0001;
        cyc();
        t_valid = 4'b0000;
        cyc();
        clr_logs();
        t_valid = 4'b1111;
        t_last  = 4'b1101;
        t_data[1*DW +: DW] = 32'hC1;
        cyc();
        t_data[1*DW +: DW] = 32'hC2;
        cyc();
        t_valid = 4'b1101;
        #1;
        chk("lock_gap_ready", 64'(t_ready), 64'd0);
        cyc();
        t_valid = 4'b1111;
        t_last  = 4'b1111;
        t_data[1*DW +: DW] = 32'hC3;
        cyc();
        cyc();
        chk("lock_nacc", 64'(acc_ids.size()), 64'd4);
        if (acc_ids.size() == 4) begin
            chk("lock_acc0", 64'(acc_ids[0]), 64'd1);
            chk("lock_acc1", 64'(acc_ids[1]), 64'd1);
            chk("lock_acc2", 64'(acc_ids[2]), 64'd1);
            chk("lock_next", 64'(acc_ids[3]), 64'd2);
        end
        t_valid = 4'b0000;
        repeat (2) cyc();
        set_pay(8'hA0);
`endif

        // Reset while FULL under backpressure
        t_valid = 4'b1111;
        i_ready = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_full", 64'(t_ready), 64'd0);
        #2;
        rstf = 1'b0;
        #1;
        chk("async_i_valid", 64'(i_valid), 64'd0);
        chk("async_t_ready", 64'(t_ready), 64'd0);
        set_pay(8'hB0);
        repeat (2) cyc();
        rstf = 1'b1;
        clr_logs();
        i_ready = 1'b1;
        repeat (4) cyc();
        if (acc_ids.size() > 0) chk("post_rst_acc0", 64'(acc_ids[0]), 64'd0);
        else chk("post_rst_acc_none", 64'd0, 64'd1);
        chk("post_rst_npop", 64'(pop_data.size()), 64'd3);
        foreach (pop_data[i]) chk("post_rst_data", 64'(pop_data[i][7:4]), 64'hB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
